// File: rtl/kf_seq_ctrl.sv
// Stage sequencer for the Kalman filter datapath: walks INIT..SCO, counts iterations,
// watches each wait state with a watchdog and reports timeouts through ERR.
module kf_seq_ctrl #(
    parameter int unsigned ITER_W = 8,
    parameter int unsigned TO_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] iter_limit,
    input  logic [TO_W-1:0]   timeout_cycles,
    input  logic              init_valid,
    input  logic              sp_done,
    input  logic              ckg_done,
    input  logic              mdi_valid,
    input  logic              scu_done_s,
    input  logic              scu_done_p,
    input  logic              sco_valid,
    input  logic              end_valid,
    output logic              en_init,
    output logic              en_sp,
    output logic              en_ckg,
    output logic              en_mdi,
    output logic              en_scu,
    output logic              en_sco,
    output logic              busy,
    output logic              finish,
    output logic              error,
    output logic [2:0]        err_stage,
    output logic [ITER_W-1:0] iter_count
);

    // Stage states carry their err_stage code in the low three bits.
    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StInit = 4'd1,
        StSp   = 4'd2,
        StCkg  = 4'd3,
        StMdi  = 4'd4,
        StScu  = 4'd5,
        StSco  = 4'd6,
        StDone = 4'd7,
        StErr  = 4'd8
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        state_raw;
    logic              start_q;
    logic              start_edge;
    logic [ITER_W-1:0] limit_q;
    logic [ITER_W-1:0] iter_d;
    logic [ITER_W-1:0] iter_inc;
    logic [TO_W-1:0]   tmo_q;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              scu_s_q, scu_s_d;
    logic              scu_p_q, scu_p_d;
    logic [2:0]        err_d;
    logic              in_wait;
    logic              adv;
    logic              to_hit;
    logic              state_chg;

    always_comb begin
        state_raw  = state_q;
        start_edge = start & ~start_q;
        in_wait    = (state_q >= StInit) && (state_q <= StSco);
        to_hit     = in_wait && (tmo_q != '0) && (wd_q == tmo_q - TO_W'(1));
        iter_inc   = (iter_count == '1) ? iter_count : iter_count + ITER_W'(1);

        state_d = state_q;
        iter_d  = iter_count;
        err_d   = err_stage;
        adv     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d = StInit;
                    iter_d  = '0;
                end
            end
            StInit: begin
                if (init_valid) begin
                    adv     = 1'b1;
                    state_d = StSp;
                end
            end
            StSp: begin
                if (sp_done) begin
                    adv     = 1'b1;
                    state_d = StCkg;
                end
            end
            StCkg: begin
                if (ckg_done) begin
                    adv     = 1'b1;
                    state_d = StMdi;
                end
            end
            StMdi: begin
                if (mdi_valid) begin
                    adv     = 1'b1;
                    state_d = StScu;
                end
            end
            StScu: begin
                if ((scu_done_s | scu_s_q) && (scu_done_p | scu_p_q)) begin
                    adv     = 1'b1;
                    state_d = StSco;
                end
            end
            StSco: begin
                if (end_valid) begin
                    adv     = 1'b1;
                    state_d = StDone;
                end else if (sco_valid) begin
                    adv     = 1'b1;
                    iter_d  = iter_inc;
                    state_d = ((limit_q != '0) && (iter_inc == limit_q)) ? StDone : StSp;
                end
            end
            StDone: state_d = StIdle;
            default: ;
        endcase

        // A done on the timeout cycle still wins.
        if (to_hit && !adv) begin
            state_d = StErr;
            err_d   = state_raw[2:0];
        end

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            iter_d  = iter_count;
            err_d   = '0;
        end

        state_chg = (state_d != state_q);
        wd_d      = (state_chg || !in_wait || (tmo_q == '0)) ? '0 : wd_q + TO_W'(1);
        scu_s_d   = !state_chg && (scu_s_q || ((state_q == StScu) && scu_done_s));
        scu_p_d   = !state_chg && (scu_p_q || ((state_q == StScu) && scu_done_p));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            limit_q    <= '0;
            tmo_q      <= '0;
            wd_q       <= '0;
            scu_s_q    <= 1'b0;
            scu_p_q    <= 1'b0;
            iter_count <= '0;
            err_stage  <= '0;
            en_init    <= 1'b0;
            en_sp      <= 1'b0;
            en_ckg     <= 1'b0;
            en_mdi     <= 1'b0;
            en_scu     <= 1'b0;
            en_sco     <= 1'b0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            wd_q       <= wd_d;
            scu_s_q    <= scu_s_d;
            scu_p_q    <= scu_p_d;
            iter_count <= iter_d;
            err_stage  <= err_d;
            if ((state_q == StIdle) && start_edge) begin
                limit_q <= iter_limit;
                tmo_q   <= timeout_cycles;
            end
            // Outputs are registered from the next state so they line up with state_q.
            en_init <= (state_d == StInit);
            en_sp   <= (state_d == StSp);
            en_ckg  <= (state_d == StCkg);
            en_mdi  <= (state_d == StMdi);
            en_scu  <= (state_d == StScu);
            en_sco  <= (state_d == StSco);
            busy    <= (state_d >= StInit) && (state_d <= StSco);
            finish  <= (state_d == StDone);
            error   <= (state_d == StErr);
        end
    end

endmodule

// File: tb/tb_kf_seq_ctrl.sv
// Scoreboard bench for kf_seq_ctrl: a cycle-level stage model pushes expected outputs,
// a monitor pops and compares them after every rising edge.
module tb_kf_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [7:0]  iter_limit;
    logic [15:0] timeout_cycles;
    logic        init_valid, sp_done, ckg_done, mdi_valid;
    logic        scu_done_s, scu_done_p, sco_valid, end_valid;
    logic        en_init, en_sp, en_ckg, en_mdi, en_scu, en_sco;
    logic        busy, finish, error;
    logic [2:0]  err_stage;
    logic [7:0]  iter_count;

    always #5 clk = ~clk;

    kf_seq_ctrl #(.ITER_W(8), .TO_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .iter_limit(iter_limit), .timeout_cycles(timeout_cycles),
        .init_valid(init_valid), .sp_done(sp_done), .ckg_done(ckg_done),
        .mdi_valid(mdi_valid), .scu_done_s(scu_done_s), .scu_done_p(scu_done_p),
        .sco_valid(sco_valid), .end_valid(end_valid),
        .en_init(en_init), .en_sp(en_sp), .en_ckg(en_ckg), .en_mdi(en_mdi),
        .en_scu(en_scu), .en_sco(en_sco), .busy(busy), .finish(finish),
        .error(error), .err_stage(err_stage), .iter_count(iter_count)
    );

    typedef struct packed {
        logic [5:0] en;   // {sco, scu, mdi, ckg, sp, init}
        logic [2:0] st;   // {busy, finish, error}
        logic [2:0] es;
        logic [7:0] it;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: stage 0 = idle, 1..6 = INIT..SCO, 7 = done, 8 = error.
    int m_stg, m_cyc, m_iters, m_limit, m_tmo, m_err;
    bit m_prev, m_seen_s, m_seen_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_step();
        int nxt;
        bit edge_s;
        if (!rst_n) begin
            m_stg = 0; m_cyc = 0; m_iters = 0; m_limit = 0; m_tmo = 0; m_err = 0;
            m_prev = 0; m_seen_s = 0; m_seen_p = 0;
            return;
        end
        edge_s = start && !m_prev;
        m_prev = start;
        nxt    = m_stg;
        if (abort && m_stg != 0) begin
            nxt   = 0;
            m_err = 0;
        end else begin
            case (m_stg)
                0: if (edge_s) begin
                    nxt = 1; m_iters = 0; m_limit = iter_limit; m_tmo = timeout_cycles;
                end
                1: if (init_valid) nxt = 2;
                2: if (sp_done)    nxt = 3;
                3: if (ckg_done)   nxt = 4;
                4: if (mdi_valid)  nxt = 5;
                5: if ((scu_done_s || m_seen_s) && (scu_done_p || m_seen_p)) nxt = 6;
                6: if (end_valid) nxt = 7;
                   else if (sco_valid) begin
                       if (m_iters < 255) m_iters++;
                       nxt = (m_limit != 0 && m_iters == m_limit) ? 7 : 2;
                   end
                7: nxt = 0;
                default: ;
            endcase
            if (m_stg >= 1 && m_stg <= 6 && nxt == m_stg && m_tmo != 0 && m_cyc + 1 == m_tmo) begin
                nxt   = 8;
                m_err = m_stg;
            end
        end
        if (nxt != m_stg) begin
            m_cyc = 0; m_seen_s = 0; m_seen_p = 0;
        end else begin
            m_cyc++;
            if (m_stg == 5) begin
                m_seen_s = m_seen_s || scu_done_s;
                m_seen_p = m_seen_p || scu_done_p;
            end
        end
        m_stg = nxt;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.en = (m_stg >= 1 && m_stg <= 6) ? 6'(1 << (m_stg - 1)) : 6'd0;
        e.st = {(m_stg >= 1 && m_stg <= 6), (m_stg == 7), (m_stg == 8)};
        e.es = 3'(m_err);
        e.it = 8'(m_iters);
        return e;
    endfunction

    // Inputs for the coming edge are already driven; model it and wait one cycle.
    task automatic tick();
        model_step();
        exp_q.push_back(expect_now());
        @(negedge clk);
    endtask

    task automatic clear_ins();
        init_valid = 0; sp_done = 0; ckg_done = 0; mdi_valid = 0;
        scu_done_s = 0; scu_done_p = 0; sco_valid = 0; end_valid = 0; abort = 0;
    endtask

    // Engines answer after a fixed number of cycles in their stage.
    task automatic drive_resp(input int d, input int ds, input int dp, input int dsp, input bit be);
        init_valid = (m_stg == 1 && m_cyc == d);
        sp_done    = (m_stg == 2 && m_cyc == dsp);
        ckg_done   = (m_stg == 3 && m_cyc == d);
        mdi_valid  = (m_stg == 4 && m_cyc == d);
        scu_done_s = (m_stg == 5 && m_cyc == ds);
        scu_done_p = (m_stg == 5 && m_cyc == dp);
        sco_valid  = (m_stg == 6 && m_cyc == d);
        end_valid  = be && (m_stg == 6 && m_cyc == d);
    endtask

    task automatic start_pulse(input int lim, input int tmo);
        clear_ins();
        iter_limit = 8'(lim); timeout_cycles = 16'(tmo);
        start = 1; tick(); start = 0;
    endtask

    task automatic run(input int d, input int ds, input int dp, input int dsp, input bit be,
                       input int budget);
        int n = 0;
        do begin
            drive_resp(d, ds, dp, dsp, be);
            tick();
            n++;
        end while (m_stg != 0 && m_stg != 8 && n < budget);
        check("run_budget", 32'(n >= budget), 32'd0);
        clear_ins();
        repeat (2) tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("enables", 32'({en_sco, en_scu, en_mdi, en_ckg, en_sp, en_init}), 32'(e.en));
                check("status", 32'({busy, finish, error}), 32'(e.st));
                check("err_stage", 32'(err_stage), 32'(e.es));
                check("iter_count", 32'(iter_count), 32'(e.it));
            end
        end
    end

    initial begin : stim
        int n;
        rst_n = 0; start = 0; iter_limit = 0; timeout_cycles = 0;
        clear_ins();
        repeat (3) tick();
        rst_n = 1;
        repeat (2) tick();

        // Nominal three-iteration run.
        start_pulse(3, 0);
        run(2, 2, 2, 2, 0, 200);

        // SCU dones in different cycles, then the same cycle.
        start_pulse(1, 0);
        run(0, 4, 1, 0, 0, 50);
        start_pulse(1, 0);
        run(0, 2, 2, 0, 0, 50);

        // Watchdog expiry in SP, ignored start in ERR, abort out.
        start_pulse(0, 4);
        run(0, 0, 0, 100, 0, 50);
        repeat (2) tick();
        start = 1; tick(); start = 0; tick();
        abort = 1; tick(); abort = 0;
        repeat (2) tick();
        // sp_done on the last allowed cycle still advances.
        start_pulse(1, 4);
        run(0, 0, 0, 3, 0, 50);

        // end_valid beats sco_valid.
        start_pulse(0, 0);
        run(0, 0, 0, 0, 1, 50);

        // Abort in CKG, start edge while busy, stale sp_done in MDI.
        start_pulse(0, 0);
        n = 0;
        while (m_stg != 0 && n < 100) begin
            drive_resp(3, 3, 3, 3, 0);
            start = (m_stg == 2 && m_cyc == 1);
            if (m_stg == 4) sp_done = 1;
            abort = (m_stg == 3 && m_cyc == 1 && m_iters == 1);
            tick();
            n++;
        end
        check("abort_budget", 32'(n >= 100), 32'd0);
        clear_ins(); start = 0;
        repeat (2) tick();

        // Reset during SCU with start held high across release.
        start_pulse(1, 0);
        n = 0;
        while (m_stg != 5 && n < 50) begin
            drive_resp(2, 2, 2, 2, 0);
            tick();
            n++;
        end
        clear_ins();
        start = 1; rst_n = 0;
        #1;
        check("async_reset", 32'({en_init, en_sp, en_ckg, en_mdi, en_scu, en_sco, busy, finish,
                                  error, err_stage, iter_count}), 32'd0);
        repeat (2) tick();
        iter_limit = 1; timeout_cycles = 0;
        rst_n = 1;
        tick();
        run(1, 1, 1, 1, 0, 50);
        start = 0;
        repeat (2) tick();

        // Iteration count saturation with unlimited iterations.
        start_pulse(0, 0);
        n = 0;
        while (n < 1400) begin
            drive_resp(0, 0, 0, 0, 0);
            tick();
            n++;
        end
        run(0, 0, 0, 0, 1, 20);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            start          = ($urandom_range(0, 9) == 0);
            abort          = ($urandom_range(0, 39) == 0);
            init_valid     = ($urandom_range(0, 99) < 35);
            sp_done        = ($urandom_range(0, 99) < 35);
            ckg_done       = ($urandom_range(0, 99) < 35);
            mdi_valid      = ($urandom_range(0, 99) < 35);
            scu_done_s     = ($urandom_range(0, 99) < 35);
            scu_done_p     = ($urandom_range(0, 99) < 35);
            sco_valid      = ($urandom_range(0, 99) < 35);
            end_valid      = ($urandom_range(0, 99) < 5);
            iter_limit     = 8'($urandom_range(0, 3));
            timeout_cycles = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 6)) : 16'd0;
            tick();
        end
        clear_ins(); start = 0;
        repeat (2) tick();

        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kf_seq_ctrl.md
# kf_seq_ctrl

Parametrised next-generation sequencer for the Kalman filter datapath. It steps the INIT → SP → CKG → MDI → SCU → SCO stage sequence and adds zero-bubble done handling, a bounded iteration count, a per-stage watchdog timeout with an error state, abort, and a single-cycle finish pulse. It sits between the top-level host control and the stage engines; it is the only source of stage enables.

## Interface
Parameters:
- ITER_W, 8: width of iteration limit and counter.
- TO_W, 16: width of watchdog timeout and counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request, rising-edge detected.
- abort  in  1  level; forces return to IDLE.
- iter_limit  in  ITER_W  number of iterations; 0 means unlimited; sampled on start edge.
- timeout_cycles  in  TO_W  maximum cycles per wait state; 0 disables the watchdog; sampled on start edge.
- init_valid, sp_done, ckg_done, mdi_valid, scu_done_s, scu_done_p, sco_valid, end_valid  in  1 each  stage completion pulses or levels.
- en_init, en_sp, en_ckg, en_mdi, en_scu, en_sco  out  1 each  stage enables; exactly one is high in the matching state.
- busy  out  1  high in INIT through SCO.
- finish  out  1  one-cycle pulse on normal completion.
- error  out  1  high while in ERR.
- err_stage  out  3  stage code that timed out: INIT=1, SP=2, CKG=3, MDI=4, SCU=5, SCO=6. Holds until cleared.
- iter_count  out  ITER_W  completed iterations in the current or last run.

## Operation
- States: IDLE, INIT, SP, CKG, MDI, SCU, SCO, DONE, ERR (4-bit encoding).
- IDLE: a start rising edge moves to INIT. The edge detector's delay flop resets to 0, so start held high through reset release counts as one edge. Start edges outside IDLE are ignored, not queued.
- INIT entry: clears iter_count; iter_limit and timeout_cycles have been registered on the start edge.
- Stage advance:
  - INIT→SP on init_valid.
  - SP→CKG on sp_done.
  - CKG→MDI on ckg_done.
  - MDI→SCU on mdi_valid.
  - SCU→SCO once both scu_done_s and scu_done_p are seen. They may arrive in different cycles or the same cycle.
- Done handling:
  - Each wait state advances on (live input OR latched input), so a done sampled at edge t leaves the state at edge t with no bubble.
  - Latches set only in their own state, clear on any state change, and clear on abort.
  - Done inputs asserted in other states are ignored.
- SCO:
  - end_valid (live or latched) → DONE. end_valid wins over sco_valid in the same cycle.
  - Otherwise sco_valid → iter_count increments (saturating at all-ones).
  - After the increment: if iter_limit≠0 and the new count equals iter_limit → DONE; else → SP.
- DONE: finish=1 for exactly one cycle, then IDLE. iter_count holds its value.
- Watchdog:
  - Counter clears on every state entry.
  - If timeout_cycles≠0 and the state has lasted timeout_cycles cycles with no qualifying done → ERR.
  - err_stage is loaded with the current stage code.
- ERR: error=1, all enables 0. Leaves only on abort → IDLE, which clears error and err_stage. Start edges are ignored in ERR.
- Priority per cycle: abort > done advance > timeout. A done arriving on the timeout cycle advances the state.
- abort in any state other than IDLE: → IDLE next edge. No finish; latches cleared; iter_count holds.

## Timing
- Reset values: state IDLE; all en_* 0; busy, finish, error 0; err_stage 0; iter_count 0; all latches and counters 0.
- All outputs are decoded from registered state or registered values; there are no combinational input→output paths.
- Start edge at edge t (start high, delay flop low) → en_init high from t+1.
- Stage done sampled at edge t → next stage's enable high from t+1, i.e. one cycle per stage minimum.
- Minimum run with iter_limit=1, all dones tied high: INIT, SP, CKG, MDI, SCU, SCO, DONE = 7 cycles, then IDLE.
- Timeout with timeout_cycles=N: the state is occupied for exactly N cycles; ERR appears on cycle N+1.

## Test plan
- Nominal run: iter_limit=3, dones pulsed 2 cycles after each enable → SP entered 3 times, iter_count 1→2→3, finish pulses once, iter_count=3 held in IDLE.
- Split SCU dones: scu_done_p at SCU cycle 2, scu_done_s at cycle 5 → SCO enable from cycle 6. Both in the same cycle → SCO next cycle.
- Timeout: timeout_cycles=4, sp_done never asserted → en_sp high 4 cycles, then error=1, err_stage=2. abort → IDLE, error=0, err_stage=0. Also sp_done on the 4th cycle → CKG, no error.
- End priority: in SCO assert sco_valid and end_valid together, iter_limit=0 → DONE, finish pulse, iter_count unchanged.
- Abort mid-run: abort in CKG → IDLE next cycle, finish stays 0. A start edge while busy has no effect. A stale sp_done pulse in MDI is ignored.
- Reset mid-run: rst_n low during SCU → all outputs 0 immediately. start held high across release → INIT one cycle after release.
